// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU).
// One result bit per cycle; HI/LO also writable directly via MTHI/MTLO.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hi_wr,
    input  logic                  lo_wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W = DATA_WIDTH;
    localparam logic [5:0] LAST = 6'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [5:0]       cnt_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   acc_d;
    logic [W-1:0]     mag_q;
    logic             is_div_q;
    logic             neg_q;
    logic             rneg_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;

    logic [W:0]       sum;
    logic [W:0]       rsh;
    logic [W:0]       rdif;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     quot;
    logic [W-1:0]     rem;
    logic [W-1:0]     res_hi;
    logic [W-1:0]     res_lo;

    // Operand magnitudes and signs; signed ops work on |a| and |b|.
    always_comb begin
        sgn   = ~op[0];
        a_neg = sgn & a[W-1];
        b_neg = sgn & b[W-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    // acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        acc_d = acc_q;
        sum   = '0;
        rsh   = '0;
        rdif  = '0;
        if (is_div_q) begin
            rsh  = acc_q[2*W-1:W-1];
            rdif = rsh - {1'b0, mag_q};
            if (rsh >= {1'b0, mag_q}) begin
                acc_d = {rdif[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_d = {rsh[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end else begin
            sum   = {1'b0, acc_q[2*W-1:W]}
                  + (acc_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});
            acc_d = {sum, acc_q[W-1:1]};
        end
    end

    // Sign correction of the final iteration's result.
    always_comb begin
        prod   = neg_q ? (~acc_d + 1'b1) : acc_d;
        quot   = acc_d[W-1:0];
        rem    = acc_d[2*W-1:W];
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
        if (is_div_q) begin
            res_lo = neg_q ? (~quot + 1'b1) : quot;
            res_hi = rneg_q ? (~rem + 1'b1) : rem;
        end
    end

    // Control FSM, iteration state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    dz_q   <= 1'b0;
                    if (hi_wr) hi_q <= wdata;
                    if (lo_wr) lo_q <= wdata;
                    if (start) begin
                        is_div_q <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        zero_q   <= (b == '0);
                        mag_q    <= op[1] ? b_mag : a_mag;
                        acc_q    <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                        if (is_div_q && zero_q) begin
                            dz_q <= 1'b1;
                        end else begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    dz_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected HI/LO,
// monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: consumes one scoreboard entry per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    chk("hi", {32'd0, hi}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo}, {32'd0, e.lo});
                    chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                    chk("latency", 64'(cyc), 64'(e.due));
                    chk("busy_at_done", {63'd0, busy}, 64'd0);
                end
            end else begin
                chk("dz_without_done", {63'd0, div_zero}, 64'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit push,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dz  = edz;
            e.due = cyc + 33;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle",
                     busy, done);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz);
        issue(o, x, y, 1'b1, ehi, elo, edz);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, div_zero}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30, 1'b0);

        @(negedge clk);
        hi_wr = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        hi_wr = 1'b0;
        lo_wr = 1'b1;
        wdata = 32'h5678;
        @(negedge clk);
        lo_wr = 1'b0;
        chk("mthi", {32'd0, hi}, 64'h1234);
        chk("mtlo", {32'd0, lo}, 64'h5678);
        run(2'b11, 32'd55, 32'd0, 32'h1234, 32'h5678, 1'b1);

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
              32'd0, 32'h8000_0000, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore_start", {63'd0, busy}, 64'd1);
        wait_idle();
        repeat (40) @(negedge clk);
        chk("no_second_op", {63'd0, busy}, 64'd0);

        run(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

        issue(2'b00, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", {63'd0, busy}, 64'd0);

        run(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
